maxpool2x2_stream: RTL

Streaming 2x2, stride-2 max-pooling stage for the U-Net encoder. It sits directly downstream of the BatchNorm+ReLU stage and takes that stage's `feature_out` / `feature_valid_out` stream. It emits one pooled feature per 2x2 window, producing a (IMG_HEIGHT/2) x (IMG_WIDTH/2) x CHANNELS stream for the next convolution. A half-width line buffer holds partial row results, so no full-frame storage is needed.

---
 rtl/maxpool2x2_stream.sv | 131 +++++++++++++
 1 files changed

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling over a channel-major, row-major feature stream.
// Half-width line buffer keeps the horizontal maxima of each even row until the odd row pairs with it.
module maxpool2x2_stream #(
  parameter int IMG_HEIGHT = 256,
  parameter int IMG_WIDTH  = 256,
  parameter int CHANNELS   = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] feature_in,
  input  logic                  feature_valid,
  output logic [DATA_WIDTH-1:0] pooled_out,
  output logic                  pooled_valid,
  output logic                  pool_done
);

  // state   | meaning
  // IDLE    | waiting for start, inputs ignored
  // POOLING | accepting samples, emitting one max per 2x2 window
  // DONE    | frame complete, pool_done held, inputs ignored until start

  localparam int CW        = $clog2(IMG_WIDTH);
  localparam int RW        = $clog2(IMG_HEIGHT);
  localparam int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LB_DEPTH  = IMG_WIDTH / 2;
  localparam int LBW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int OUT_TOTAL = (IMG_HEIGHT / 2) * (IMG_WIDTH / 2) * CHANNELS;
  localparam int OCW       = $clog2(OUT_TOTAL + 1);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POOLING,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [CHW-1:0]        ch;
  logic [OCW-1:0]        out_cnt;
  logic [DATA_WIDTH-1:0] h_hold;
  logic [DATA_WIDTH-1:0] line_buf [LB_DEPTH];

  logic                  accept;
  logic                  win_done;
  logic                  frame_end;
  logic [LBW-1:0]        lb_idx;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] vmax;

  assign accept   = (state == S_POOLING) && feature_valid;
  assign win_done = col[0] && row[0];
  // The window that yields the last strobe is always the frame's final sample.
  assign frame_end = accept && win_done && (out_cnt == OUT_LAST);
  assign lb_idx   = LBW'(col >> 1);
  assign lb_rd    = line_buf[lb_idx];
  assign hmax     = (feature_in > h_hold) ? feature_in : h_hold;
  assign vmax     = (lb_rd > hmax) ? lb_rd : hmax;

  assign pool_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_POOLING;
      S_POOLING: if (frame_end) state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_POOLING;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      ch           <= '0;
      out_cnt      <= '0;
      h_hold       <= '0;
      pooled_out   <= '0;
      pooled_valid <= 1'b0;
    end else begin
      pooled_valid <= 1'b0;
      if (start && (state != S_POOLING)) begin
        col     <= '0;
        row     <= '0;
        ch      <= '0;
        out_cnt <= '0;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row <= '0;
            ch  <= (ch == CH_LAST) ? '0 : ch + CHW'(1);
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end

        if (!col[0]) begin
          h_hold <= feature_in;
        end else if (row[0]) begin
          pooled_out   <= vmax;
          pooled_valid <= 1'b1;
          out_cnt      <= out_cnt + OCW'(1);
        end
      end
    end
  end

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) line_buf[lb_idx] <= hmax;
  end

endmodule
